// File: rtl/sprite_plotter.sv
// Rectangle plotter for press/garbage sprites: one pixel per cycle, row-major, into a VGA adapter.
// Latency: LOAD one cycle after start, then W*H plot cycles, then a one-cycle done pulse; start ignored while busy.
module sprite_plotter #(
    parameter int       LANE_W    = 40,
    parameter int       PRESS_W   = 40,
    parameter int       PRESS_H   = 60,
    parameter int       GARB_W    = 20,
    parameter int       GARB_H    = 20,
    parameter int       GARB_XOFF = 10,
    parameter int       GARB_Y    = 90,
    parameter logic [2:0] PRESS_COL = 3'b111,
    parameter logic [2:0] GARB_COL  = 3'b010
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       start,
    input  logic       item,
    input  logic       erase,
    input  logic [1:0] position,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    state_t     state, state_nx;
    logic       item_r, erase_r;
    logic [1:0] pos_r;
    logic [7:0] x0;
    logic [5:0] w, h, col, row;
    logic [7:0] lane_x;
    logic       col_last, last_px;

    assign lane_x   = {6'd0, pos_r} * 8'(LANE_W);
    assign col_last = (col == w - 6'd1);
    assign last_px  = col_last && (row == h - 6'd1);

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = SCAN;
            SCAN:    if (last_px) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // x/y are the current pixel registers: set to the origin in LOAD, stepped in SCAN, held otherwise
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            item_r  <= 1'b0;
            erase_r <= 1'b0;
            pos_r   <= 2'd0;
            x0      <= 8'd0;
            w       <= 6'd0;
            h       <= 6'd0;
            col     <= 6'd0;
            row     <= 6'd0;
            x       <= 8'd0;
            y       <= 7'd0;
            colour  <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        item_r  <= item;
                        erase_r <= erase;
                        pos_r   <= position;
                    end
                end
                LOAD: begin
                    col <= 6'd0;
                    row <= 6'd0;
                    if (item_r) begin
                        x0     <= lane_x;
                        x      <= lane_x;
                        y      <= 7'd0;
                        w      <= 6'(PRESS_W);
                        h      <= 6'(PRESS_H);
                        colour <= erase_r ? 3'b000 : PRESS_COL;
                    end else begin
                        x0     <= lane_x + 8'(GARB_XOFF);
                        x      <= lane_x + 8'(GARB_XOFF);
                        y      <= 7'(GARB_Y);
                        w      <= 6'(GARB_W);
                        h      <= 6'(GARB_H);
                        colour <= erase_r ? 3'b000 : GARB_COL;
                    end
                end
                SCAN: begin
                    if (col_last) begin
                        col <= 6'd0;
                        row <= row + 6'd1;
                        x   <= x0;
                        y   <= y + 7'd1;
                    end else begin
                        col <= col + 6'd1;
                        x   <= x + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == LOAD) || (state == SCAN);
    assign done = (state == DONE);
    assign plot = (state == SCAN);

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: stimulus pushes expected pixels/done cycles, a negedge monitor pops and compares.
module tb_sprite_plotter;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       start    = 1'b0;
    logic       item     = 1'b0;
    logic       erase    = 1'b0;
    logic [1:0] position = 2'd0;
    logic       busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    sprite_plotter dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .item(item),
        .erase(erase), .position(position), .busy(busy), .done(done),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int px;
        int py;
        int pc;
        int t;
    } pix_t;

    pix_t pq[$];
    int   dq[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // expected pixels of one command accepted at cycle t0; npix < W*H models an aborted command
    task automatic push_cmd(input bit it, input bit er, input int p, input int t0,
                            input int npix, input bit exp_done);
        int w, h, x0, y0, c;
        w  = it ? 40 : 20;
        h  = it ? 60 : 20;
        x0 = p * 40 + (it ? 0 : 10);
        y0 = it ? 0 : 90;
        c  = er ? 0 : (it ? 7 : 2);
        for (int i = 0; i < npix; i++)
            pq.push_back('{x0 + i % w, y0 + i / w, c, t0 + 2 + i});
        if (exp_done) dq.push_back(t0 + w * h + 2);
    endtask

    task automatic issue(input bit it, input bit er, input logic [1:0] p,
                         input int npix, input bit exp_done);
        int t0;
        t0       = cyc;
        item     = it;
        erase    = er;
        position = p;
        start    = 1'b1;
        push_cmd(it, er, int'(p), t0, npix, exp_done);
        tick();
        start = 1'b0;
        chk("load_busy", int'(busy), 1);
        chk("load_plot", int'(plot), 0);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((pq.size() != 0 || dq.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        chk("drain_left", pq.size() + dq.size(), 0);
        repeat (3) tick();
        chk("idle_busy", int'(busy), 0);
    endtask

    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            if (plot) begin
                total++;
                if (pq.size() == 0) begin
                    bad++;
                    $display("FAIL stray_plot: got (%0d,%0d) at cycle %0d expected no plot", x, y, cyc);
                end else begin
                    pix_t e;
                    e = pq.pop_front();
                    if (int'(x) != e.px || int'(y) != e.py || int'(colour) != e.pc || cyc != e.t) begin
                        bad++;
                        $display("FAIL pixel: got x=%0d y=%0d c=%0d t=%0d expected x=%0d y=%0d c=%0d t=%0d",
                                 x, y, colour, cyc, e.px, e.py, e.pc, e.t);
                    end
                end
            end
            if (done) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL stray_done: got done at cycle %0d expected none", cyc);
                end else begin
                    int et;
                    et = dq.pop_front();
                    if (cyc != et || busy || plot) begin
                        bad++;
                        $display("FAIL done_pulse: got t=%0d busy=%0d plot=%0d expected t=%0d busy=0 plot=0",
                                 cyc, busy, plot, et);
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        // reset wins over a simultaneous start
        start = 1'b1;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        start   = 1'b0;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();
        chk("post_rst_busy", int'(busy), 0);

        // garbage draw, lane 2
        issue(1'b0, 1'b0, 2'd2, 400, 1'b1);
        drain(600);

        // press erase, lane 3; inputs scrambled after acceptance
        issue(1'b1, 1'b1, 2'd3, 2400, 1'b1);
        item = 1'b0; erase = 1'b0; position = 2'd0;
        drain(2600);

        // second start during a garbage command is ignored
        t0 = cyc;
        issue(1'b0, 1'b0, 2'd0, 400, 1'b1);
        while (cyc < t0 + 100) tick();
        item = 1'b1; position = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("scan_busy", int'(busy), 1);
        drain(600);

        // reset at cycle 50 of a press draw: pixels for cycles 2..50 only, no done
        t0 = cyc;
        issue(1'b1, 1'b0, 2'd1, 49, 1'b0);
        while (cyc < t0 + 50) tick();
        reset_n = 1'b0;
        tick();
        chk("abort_plot", int'(plot), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        reset_n = 1'b1;
        tick();
        chk("abort_left", pq.size(), 0);
        issue(1'b0, 1'b0, 2'd3, 400, 1'b1);
        drain(600);

        // start held high: three commands with period 403
        t0       = cyc;
        item     = 1'b0;
        erase    = 1'b0;
        position = 2'd1;
        start    = 1'b1;
        for (int k = 0; k < 3; k++) push_cmd(1'b0, 1'b0, 1, t0 + 403 * k, 400, 1'b1);
        while (cyc < t0 + 807) tick();
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        drain(1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
